// File: rtl/cp2_fetch_ctrl.sv
// cp2_fetch_ctrl
// ---------------------------------------------------------------------------
// Fetch sequencer for the cp2 core. Owns the program counter. Reads
// instruction words from memory over a req/ack handshake. Hands each word to
// the fetch stage as a one-cycle irenable pulse alongside ir.
//
// Memory handshake: mem_req rises with a stable mem_addr and stays high,
// with mem_addr unchanged, until the cycle in which mem_ack is sampled high.
// mem_rdata is valid only in that cycle. A request is never withdrawn
// before its ack. The exceptions are reset and watchdog expiry, which
// abandon it.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-low reset
//   run        enable fetching
//   stall      downstream cannot accept a word this cycle
//   flush      one-cycle redirect request
//   flush_pc   redirect target, sampled with flush
//   mem_ack    memory read complete, mem_rdata valid
//   mem_rdata  instruction word from memory
//   mem_req    read request, held until acked
//   mem_addr   read address
//   pc         address of the next word to fetch
//   irenable   one-cycle pulse: ir holds a new instruction
//   ir         fetched instruction
//   fetch_err  one-cycle pulse on watchdog expiry
//   busy       sequencer not idle
//   fsm_state  current state encoding, for observation
// ---------------------------------------------------------------------------
module cp2_fetch_ctrl #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        PC_STEP  = 4,
    parameter int unsigned        TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              irenable,
    output logic [DATA_W-1:0] ir,
    output logic              fetch_err,
    output logic              busy,
    output logic [2:0]        fsm_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        HOLD  = 3'd2,
        ISSUE = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam int unsigned CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned ALIGN_W = (PC_STEP <= 1) ? 0 : $clog2(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << ALIGN_W) - 64'd1);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [CNT_W:0]    TMO        = (CNT_W + 1)'(TIMEOUT);

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc_d, mem_addr_d, flush_target;
    logic [DATA_W-1:0] ir_d;
    logic [CNT_W-1:0]  cnt, cnt_d, cnt_sat;
    logic [CNT_W:0]    cnt_inc;
    logic              timeout_hit;
    logic              mem_req_d, irenable_d, fetch_err_d, busy_d;

    assign flush_target = flush_pc & ALIGN_MASK;
    assign cnt_inc      = {1'b0, cnt} + 1'b1;
    // The counter holds at its maximum instead of wrapping. This only
    // matters when the watchdog is disabled.
    assign cnt_sat      = cnt_inc[CNT_W] ? cnt : cnt_inc[CNT_W-1:0];
    assign timeout_hit  = (TIMEOUT != 0) && (cnt_inc == TMO);
    assign fsm_state    = state;

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        ir_d        = ir;
        cnt_d       = '0;
        fetch_err_d = 1'b0;
        case (state)
            IDLE: begin
                if (flush) pc_d = flush_target;
                if (run) state_d = REQ;
            end
            REQ: begin
                if (mem_ack) begin
                    if (flush) begin
                        pc_d    = flush_target;
                        state_d = run ? REQ : IDLE;
                    end else begin
                        ir_d    = mem_rdata;
                        pc_d    = pc + STEP;
                        state_d = stall ? HOLD : ISSUE;
                    end
                end else if (timeout_hit) begin
                    // A dead memory wins over a redirect. pc stays put so
                    // the failing address is still visible.
                    state_d     = IDLE;
                    fetch_err_d = 1'b1;
                end else if (flush) begin
                    // The bus transfer cannot be aborted. Wait it out in DRAIN,
                    // and keep the watchdog counting on the same transfer.
                    pc_d    = flush_target;
                    state_d = DRAIN;
                    cnt_d   = cnt_sat;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_d    = flush_target;
                    state_d = run ? REQ : IDLE;
                end else if (!stall) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (flush) pc_d = flush_target;
                state_d = run ? REQ : IDLE;
            end
            DRAIN: begin
                if (mem_ack) begin
                    if (flush) pc_d = flush_target;
                    state_d = run ? REQ : IDLE;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    fetch_err_d = 1'b1;
                end else begin
                    if (flush) pc_d = flush_target;
                    cnt_d = cnt_sat;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and then registered.
        mem_req_d  = (state_d == REQ) || (state_d == DRAIN);
        mem_addr_d = (state_d == REQ) ? pc_d : mem_addr;
        irenable_d = (state_d == ISSUE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            irenable  <= 1'b0;
            fetch_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            ir        <= ir_d;
            cnt       <= cnt_d;
            mem_req   <= mem_req_d;
            mem_addr  <= mem_addr_d;
            irenable  <= irenable_d;
            fetch_err <= fetch_err_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_cp2_fetch_ctrl.sv
// tb_cp2_fetch_ctrl
// ---------------------------------------------------------------------------
// Directed bench for cp2_fetch_ctrl. The DUT is built with a watchdog of
// 8 cycles. Inputs change 1 ns after each rising edge. Outputs are checked
// at that same point, against hand-computed values.
// ---------------------------------------------------------------------------
module tb_cp2_fetch_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic              clk = 1'b0;
    logic              rst, run, stall, flush, mem_ack;
    logic [ADDR_W-1:0] flush_pc;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_req, irenable, fetch_err, busy;
    logic [ADDR_W-1:0] mem_addr, pc;
    logic [DATA_W-1:0] ir;
    logic [2:0]        fsm_state;

    int checks = 0;
    int errors = 0;

    // clock / reset
    always #5 clk = ~clk;

    cp2_fetch_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RESET_PC('0),
        .PC_STEP (4),
        .TIMEOUT (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .stall    (stall),
        .flush    (flush),
        .flush_pc (flush_pc),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .pc       (pc),
        .irenable (irenable),
        .ir       (ir),
        .fetch_err(fetch_err),
        .busy     (busy),
        .fsm_state(fsm_state)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_core(input string tag, input logic [2:0] st, input logic req,
                            input logic [31:0] addr, input logic [31:0] pcv,
                            input logic ien, input logic [31:0] irv);
        chk({tag, ".state"},    64'(fsm_state), 64'(st));
        chk({tag, ".mem_req"},  64'(mem_req),   64'(req));
        chk({tag, ".mem_addr"}, 64'(mem_addr),  64'(addr));
        chk({tag, ".pc"},       64'(pc),        64'(pcv));
        chk({tag, ".irenable"}, 64'(irenable),  64'(ien));
        chk({tag, ".ir"},       64'(ir),        64'(irv));
    endtask

    // absolute time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        rst = 1'b0; run = 1'b0; stall = 1'b0; flush = 1'b0;
        flush_pc = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();

        // reset state
        chk_core("reset", S_IDLE, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("reset.fetch_err", 64'(fetch_err), 64'd0);
        chk("reset.busy",      64'(busy),      64'd0);

        // 1: zero-wait memory, words 0xA0+addr
        rst = 1'b1; run = 1'b1;
        tick();
        chk_core("t1.req0", S_REQ, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("t1.busy", 64'(busy), 64'd1);
        mem_ack = 1'b1; mem_rdata = 32'hA0;
        tick();
        chk_core("t1.iss0", S_ISSUE, 1'b0, 32'h0, 32'h4, 1'b1, 32'hA0);
        mem_ack = 1'b0;
        tick();
        chk_core("t1.req1", S_REQ, 1'b1, 32'h4, 32'h4, 1'b0, 32'hA0);
        mem_ack = 1'b1; mem_rdata = 32'hA4;
        tick();
        chk_core("t1.iss1", S_ISSUE, 1'b0, 32'h4, 32'h8, 1'b1, 32'hA4);
        mem_ack = 1'b0;
        tick();
        chk_core("t1.req2", S_REQ, 1'b1, 32'h8, 32'h8, 1'b0, 32'hA4);
        mem_ack = 1'b1; mem_rdata = 32'hA8;
        tick();
        chk_core("t1.iss2", S_ISSUE, 1'b0, 32'h8, 32'hC, 1'b1, 32'hA8);
        mem_ack = 1'b0;

        // 2: ack delayed by 3 cycles
        tick();
        chk_core("t2.wait0", S_REQ, 1'b1, 32'hC, 32'hC, 1'b0, 32'hA8);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_core("t2.wait", S_REQ, 1'b1, 32'hC, 32'hC, 1'b0, 32'hA8);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        tick();
        chk_core("t2.iss", S_ISSUE, 1'b0, 32'hC, 32'h10, 1'b1, 32'h1234);
        mem_ack = 1'b0;
        tick();
        chk_core("t2.next", S_REQ, 1'b1, 32'h10, 32'h10, 1'b0, 32'h1234);

        // 3: stall for 5 cycles at ack; run dropped while holding
        mem_ack = 1'b1; mem_rdata = 32'h5555; stall = 1'b1;
        tick();
        chk_core("t3.hold0", S_HOLD, 1'b0, 32'h10, 32'h14, 1'b0, 32'h5555);
        mem_ack = 1'b0; run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_core("t3.hold", S_HOLD, 1'b0, 32'h10, 32'h14, 1'b0, 32'h5555);
        end
        stall = 1'b0;
        tick();
        chk_core("t3.iss", S_ISSUE, 1'b0, 32'h10, 32'h14, 1'b1, 32'h5555);
        tick();
        chk_core("t3.idle", S_IDLE, 1'b0, 32'h10, 32'h14, 1'b0, 32'h5555);
        chk("t3.busy", 64'(busy), 64'd0);
        run = 1'b1;
        tick();
        chk_core("t3.restart", S_REQ, 1'b1, 32'h14, 32'h14, 1'b0, 32'h5555);

        // 4: flush while REQ unacked -> DRAIN, discard, refetch at 0x100
        flush = 1'b1; flush_pc = 32'h103;
        tick();
        chk_core("t4.drain0", S_DRAIN, 1'b1, 32'h14, 32'h100, 1'b0, 32'h5555);
        flush = 1'b0; flush_pc = '0;
        tick();
        chk_core("t4.drain1", S_DRAIN, 1'b1, 32'h14, 32'h100, 1'b0, 32'h5555);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD;
        tick();
        chk_core("t4.refetch", S_REQ, 1'b1, 32'h100, 32'h100, 1'b0, 32'h5555);
        mem_ack = 1'b0;

        // 5: no ack -> watchdog fires 8 cycles into REQ
        run = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t5.wait.mem_req",   64'(mem_req),   64'd1);
            chk("t5.wait.fetch_err", 64'(fetch_err), 64'd0);
        end
        tick();
        chk_core("t5.expire", S_IDLE, 1'b0, 32'h100, 32'h100, 1'b0, 32'h5555);
        chk("t5.fetch_err", 64'(fetch_err), 64'd1);
        chk("t5.busy",      64'(busy),      64'd0);
        tick();
        chk("t5.err_pulse", 64'(fetch_err), 64'd0);

        // 6: reset mid-REQ, then restart from RESET_PC
        run = 1'b1;
        tick();
        chk_core("t6.req", S_REQ, 1'b1, 32'h100, 32'h100, 1'b0, 32'h5555);
        tick();
        rst = 1'b0;
        tick();
        chk_core("t6.reset", S_IDLE, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("t6.busy", 64'(busy), 64'd0);
        rst = 1'b1;
        tick();
        chk_core("t6.req0", S_REQ, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h77;
        tick();
        chk_core("t6.iss0", S_ISSUE, 1'b0, 32'h0, 32'h4, 1'b1, 32'h77);
        mem_ack = 1'b0;

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp2_fetch_ctrl.md
Name: cp2_fetch_ctrl

Overview:
Fetch sequencer for the cp2 core. It owns the program counter, runs a req/ack read handshake to instruction memory, and presents each returned word to the fetch-instruction stage as a one-cycle irenable pulse with ir. It also handles stall, flush/redirect and memory-timeout for the fetch path.

Parameters:
ADDR_W, 32, width of pc, flush_pc and mem_addr
DATA_W, 32, instruction word width (mem_rdata, ir)
RESET_PC, 0, pc value after reset
PC_STEP, 4, pc increment per fetched word
TIMEOUT, 255, max cycles waiting for mem_ack; 0 disables the watchdog

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is synchronous and active-low
run  input  1  enable fetching
stall  input  1  downstream cannot accept a word this cycle
flush  input  1  redirect request; one-cycle pulse
flush_pc  input  ADDR_W  redirect target, sampled with flush
mem_ack  input  1  memory read complete; mem_rdata valid this cycle
mem_rdata  input  DATA_W  instruction word
mem_req  output  1  read request, held until acked
mem_addr  output  ADDR_W  read address, stable while mem_req=1
pc  output  ADDR_W  address of next word to fetch
irenable  output  1  one-cycle pulse: ir holds a new instruction
ir  output  DATA_W  fetched instruction, to the fetch stage
fetch_err  output  1  one-cycle pulse on watchdog expiry
busy  output  1  state != IDLE

Behaviour:
- All outputs are registered. rst=0 at a clk edge wins over everything. State goes to IDLE, pc=RESET_PC, and mem_req, mem_addr, irenable, ir, fetch_err, busy and the timeout counter all go to 0. This applies mid-transaction too; an outstanding request is abandoned.
- States: IDLE, REQ, HOLD, ISSUE, DRAIN.
- IDLE: mem_req=0. If run=1, go to REQ next cycle with mem_addr=pc.
- REQ: mem_req=1, mem_addr=pc.
  - mem_ack=0: stay in REQ; counter increments.
  - mem_ack=1: capture ir<=mem_rdata, pc<=pc+PC_STEP (wraps mod 2^ADDR_W), counter cleared. Next state is ISSUE if stall=0, else HOLD.
  - A zero-wait memory acks in the first REQ cycle.
- HOLD: mem_req=0, irenable=0, ir held. Go to ISSUE the cycle after stall is sampled 0.
- ISSUE: irenable=1 for exactly this cycle, mem_req=0. Next state is REQ if run=1, else IDLE.
  - Minimum fetch period is 2 cycles: REQ with ack, then ISSUE.
- run deasserted mid-transaction: the current fetch completes and is issued, then the block returns to IDLE. No request is abandoned.
- flush has priority over stall and run-driven transitions. pc<=flush_pc with the low log2(PC_STEP) bits forced to 0. Behaviour depends on the state in which flush is sampled:
  - IDLE or HOLD: the captured word is discarded (no irenable). Next state is REQ if run=1, else IDLE.
  - ISSUE: the irenable pulse of this cycle stands. Next state as for IDLE/HOLD.
  - REQ without ack: the bus transfer cannot be aborted, so go to DRAIN; mem_req and mem_addr are held.
  - REQ with ack: the word is discarded. Next state as for IDLE/HOLD.
- DRAIN: mem_req=1 until mem_ack; the returned data is discarded (ir unchanged, no irenable). Then go to REQ at the flushed pc if run=1, else IDLE. A further flush while in DRAIN overwrites pc and the block stays in DRAIN.
- Watchdog (TIMEOUT>0): when the counter reaches TIMEOUT in REQ or DRAIN, fetch_err=1 for one cycle, mem_req drops, state goes to IDLE, and pc is unchanged. The counter is 0 outside REQ/DRAIN.
- Width rule: the counter is wide enough for TIMEOUT and saturates; it never wraps.

Test Plan:
1. Reset then run=1, zero-wait memory returning 0xA0+addr -> mem_addr 0,4,8 on alternate cycles; irenable every 2nd cycle; ir=0xA0,0xA4,0xA8.
2. mem_ack delayed 3 cycles -> mem_req and mem_addr stable for 4 cycles; a single irenable one cycle after ack; pc advances by 4 only once.
3. stall=1 for 5 cycles at ack -> irenable held low in HOLD; pulses exactly once, one cycle after stall falls; ir unchanged throughout.
4. flush with flush_pc=0x103 while REQ is unacked -> DRAIN; the acked data is discarded with no irenable; the next request has mem_addr=0x100.
5. TIMEOUT=8, mem_ack never asserted -> fetch_err pulses once, 8 cycles into REQ; mem_req=0; state IDLE; pc unchanged.
6. rst=0 asserted mid-REQ, then released -> all outputs 0 and pc=RESET_PC on the next edge; fetching restarts from RESET_PC when run=1.
